// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUop classes,
// datapath mux selects and FSM state codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b101010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_BLT   = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_BNE = 3'b011;
  localparam logic [2:0] ALUOP_BGT = 3'b111;
  localparam logic [2:0] ALUOP_BLT = 3'b101;

  localparam logic [1:0] SRCB_RB      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StExecI   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  // BEQ compares by subtraction; the other branches have their own ALU classes.
  function automatic logic [2:0] branch_aluop(logic [5:0] op);
    case (op)
      OP_BNE:  return ALUOP_BNE;
      OP_BGT:  return ALUOP_BGT;
      OP_BLT:  return ALUOP_BLT;
      default: return ALUOP_SUB;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: synchronous clear, single-step increment, wraps freely.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory-ready handshake and retire counter.
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes instead of retiring them as NOPs.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [3:0]         state_o,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired,
  output logic               exc
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [2:0]        aluop;
  logic              retire;
  logic [CNT_W-1:0]  count;

  // op is only valid in DECODE, so later states work from the captured copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RB;
    PCSource    = PCSRC_ALU;
    aluop       = ALUOP_ADD;
    exc         = 1'b0;

    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (op)
          OP_RTYPE:                      state_d = StExecR;
          OP_ADDI, OP_SUBI:              state_d = StExecI;
          OP_LW, OP_SW:                  state_d = StMemAddr;
          OP_BEQ, OP_BNE, OP_BGT, OP_BLT: state_d = StBranch;
          OP_J:                          state_d = StJump;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = StTrap;
`else
            retire = 1'b1;
`endif
          end
        endcase
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RB;
        aluop   = ALUOP_R;
        state_d = StRWb;
      end
      StRWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        aluop   = (op_q == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
        state_d = StIWb;
      end
      StIWb: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op_q == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RB;
        PCSource    = PCSRC_ALUOUT;
        PCWriteCond = 1'b1;
        aluop       = branch_aluop(op_q);
        retire      = 1'b1;
      end
      StJump: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        retire   = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap: begin
        exc = 1'b1;
      end
`endif
      default: state_d = StFetch;
    endcase

    if (retire) begin
      state_d = StFetch;
    end
    instr_done = retire;
    ALUop      = ALUOP_W'(aluop);
    state_o    = state_q;

    // Reset forces every output low, including any write strobe of the current state.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = '0;
      PCSource    = '0;
      ALUop       = '0;
      state_o     = '0;
      instr_done  = 1'b0;
      exc         = 1'b0;
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk_i   (clk),
    .clr_i   (rst),
    .inc_i   (instr_done),
    .count_o (count)
  );

  assign retired = rst ? '0 : count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: randomized instruction stream vs. a
// per-instruction state-sequence model built from the instruction-class latencies.
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b101010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_BLT   = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = '0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUop;
  logic [3:0]  state_o;
  logic        instr_done, exc;
  logic [31:0] retired;
  ctrl_t       obs;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned model_cnt = 0;
  int          exp_st[$];
  bit          exp_mr[$];

  multicycle_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUop       (ALUop),
    .state_o     (state_o),
    .instr_done  (instr_done),
    .retired     (retired),
    .exc         (exc)
  );

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // 0 R, 1 I-type ALU, 2 LW, 3 SW, 4 branch, 5 jump, 6 illegal
  function automatic int op_class(logic [5:0] o);
    if (o == OP_RTYPE) return 0;
    if (o == OP_ADDI || o == OP_SUBI) return 1;
    if (o == OP_LW) return 2;
    if (o == OP_SW) return 3;
    if (o == OP_BEQ || o == OP_BNE || o == OP_BGT || o == OP_BLT) return 4;
    if (o == OP_J) return 5;
    return 6;
  endfunction

  task automatic push_exp(input int s, input bit m);
    exp_st.push_back(s);
    exp_mr.push_back(m);
  endtask

  // Expected state trace of one instruction, with the mem_ready value driven each cycle.
  task automatic build_seq(input logic [5:0] iop, input int fw, input int mw);
    exp_st.delete();
    exp_mr.delete();
    repeat (fw) push_exp(0, 1'b0);
    push_exp(0, 1'b1);
    push_exp(1, 1'($urandom));
    case (op_class(iop))
      0: begin push_exp(6, 1'($urandom)); push_exp(7, 1'($urandom)); end
      1: begin push_exp(8, 1'($urandom)); push_exp(9, 1'($urandom)); end
      2: begin
        push_exp(2, 1'($urandom));
        repeat (mw) push_exp(3, 1'b0);
        push_exp(3, 1'b1);
        push_exp(4, 1'($urandom));
      end
      3: begin
        push_exp(2, 1'($urandom));
        repeat (mw) push_exp(5, 1'b0);
        push_exp(5, 1'b1);
      end
      4: push_exp(10, 1'($urandom));
      5: push_exp(11, 1'($urandom));
      default: ;
    endcase
  endtask

  // Expected control word and which bits are defined for a given state.
  function automatic void expect_ctrl(input int st, input logic [5:0] iop, input logic mr,
                                      output ctrl_t e, output ctrl_t m);
    e = '0;
    m = '0;
    m.pcw = 1; m.pcwc = 1; m.iord = 1; m.mrd = 1; m.mwr = 1; m.irw = 1; m.rw = 1;
    case (st)
      0: begin
        e.mrd = 1; e.irw = mr; e.pcw = mr; e.srcb = 2'b01;
        m.srca = 1; m.srcb = '1; m.aluop = '1;
      end
      1: begin e.srcb = 2'b11; m.srca = 1; m.srcb = '1; m.aluop = '1; end
      2: begin e.srca = 1; e.srcb = 2'b10; m.srca = 1; m.srcb = '1; m.aluop = '1; end
      3: begin e.mrd = 1; e.iord = 1; end
      4: begin e.rw = 1; e.m2r = 1; m.m2r = 1; m.rdst = 1; end
      5: begin e.mwr = 1; e.iord = 1; end
      6: begin e.srca = 1; e.aluop = 3'b010; m.srca = 1; m.srcb = '1; m.aluop = '1; end
      7: begin e.rdst = 1; e.rw = 1; m.rdst = 1; m.m2r = 1; end
      8: begin
        e.srca = 1; e.srcb = 2'b10; e.aluop = (iop == OP_SUBI) ? 3'b001 : 3'b000;
        m.srca = 1; m.srcb = '1; m.aluop = '1;
      end
      9: begin e.rw = 1; m.rdst = 1; end
      10: begin
        e.srca = 1; e.pcsrc = 2'b01; e.pcwc = 1;
        e.aluop = (iop == OP_BNE) ? 3'b011 : (iop == OP_BGT) ? 3'b111 :
                  (iop == OP_BLT) ? 3'b101 : 3'b001;
        m.srca = 1; m.srcb = '1; m.pcsrc = '1; m.aluop = '1;
      end
      11: begin e.pcsrc = 2'b10; e.pcw = 1; m.pcsrc = '1; end
      default: ;
    endcase
  endfunction

  // Runs trace entries [start, stop) of one instruction, checking every cycle.
  task automatic run_instr(input logic [5:0] iop, input int fw, input int mw,
                           input int start, input int stop);
    ctrl_t e, m;
    int    n;
    bit    retires;
    logic  want_done;
    build_seq(iop, fw, mw);
    n = (stop >= 0 && stop < exp_st.size()) ? stop : exp_st.size();
    retires = (n == exp_st.size());
`ifdef ILLEGAL_OP_TRAP_EN
    if (op_class(iop) == 6) retires = 0;
`endif
    for (int i = start; i < n; i++) begin
      @(negedge clk);
      op = (exp_st[i] == 1) ? iop : 6'($urandom);
      mem_ready = exp_mr[i];
      #1;
      if (i == start) begin
        n_cmp++;
        if (retired !== model_cnt)
          begin n_err++; $display("FAIL retired_at_start op=%b got=%0d want=%0d", iop, retired, model_cnt); end
      end
      n_cmp++;
      if (state_o !== 4'(exp_st[i]))
        begin n_err++; $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", iop, i, state_o, exp_st[i]); end
      expect_ctrl(exp_st[i], iop, exp_mr[i], e, m);
      n_cmp++;
      if ((obs & m) !== (e & m))
        begin n_err++; $display("FAIL ctrl op=%b st=%0d got=%h want=%h mask=%h", iop, exp_st[i], obs & m, e & m, m); end
      want_done = retires && (i == n - 1);
      n_cmp++;
      if (instr_done !== want_done)
        begin n_err++; $display("FAIL instr_done op=%b cyc=%0d got=%b want=%b", iop, i, instr_done, want_done); end
      n_cmp++;
      if (exc !== 1'b0)
        begin n_err++; $display("FAIL exc op=%b cyc=%0d got=%b want=0", iop, i, exc); end
    end
    if (retires) model_cnt++;
  endtask

  // Holds rst for the given cycles; every output must read zero throughout.
  task automatic do_reset(input int cycles, input logic mr);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = mr;
      op = 6'($urandom);
      #1;
      n_cmp++;
      if ({obs, state_o, retired, instr_done, exc} !== '0)
        begin n_err++; $display("FAIL reset_outputs cyc=%0d got ctrl=%h st=%0d ret=%0d done=%b exc=%b want all 0", i, obs, state_o, retired, instr_done, exc); end
    end
    model_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset(3, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || retired !== 32'd0)
      begin n_err++; $display("FAIL reset_release got st=%0d ret=%0d want st=0 ret=0", state_o, retired); end
    n_cmp++;
    if (MemRead !== 1'b1)
      begin n_err++; $display("FAIL reset_memread got=%b want=1", MemRead); end
  endtask

  task automatic test_addi();
    run_instr(OP_ADDI, 0, 0, 1, -1);  // fetch already completed in the release cycle
    run_instr(OP_SUBI, 1, 0, 0, -1);
    run_instr(OP_RTYPE, 0, 0, 0, -1);
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 0, 3, 0, -1);
    run_instr(OP_SW, 0, 2, 0, -1);
    run_instr(OP_J, 0, 0, 0, -1);
  endtask

  task automatic test_branches();
    run_instr(OP_BEQ, 0, 0, 0, -1);
    run_instr(OP_BNE, 0, 0, 0, -1);
    run_instr(OP_BGT, 2, 0, 0, -1);
    run_instr(OP_BLT, 0, 0, 0, -1);
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
    ctrl_t e, m;
    run_instr(OP_ILL, 0, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op = 6'($urandom);
      mem_ready = 1'($urandom);
      #1;
      expect_ctrl(12, OP_ILL, mem_ready, e, m);
      n_cmp++;
      if (state_o !== 4'd12 || exc !== 1'b1 || instr_done !== 1'b0)
        begin n_err++; $display("FAIL trap_hold cyc=%0d got st=%0d exc=%b done=%b want st=12 exc=1 done=0", i, state_o, exc, instr_done); end
      n_cmp++;
      if ((obs & m) !== (e & m))
        begin n_err++; $display("FAIL trap_strobes cyc=%0d got=%h want=%h", i, obs & m, e & m); end
    end
    do_reset(1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || retired !== 32'd0)
      begin n_err++; $display("FAIL trap_exit got st=%0d ret=%0d want st=0 ret=0", state_o, retired); end
`else
    run_instr(OP_ILL, 0, 0, 0, -1);
    run_instr(6'b110011, 1, 0, 0, -1);
`endif
  endtask

  task automatic test_reset_mid_sw();
    run_instr(OP_SW, 0, 5, 0, 4);  // stop in the first MEM_WR wait cycle
    do_reset(1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || retired !== 32'd0)
      begin n_err++; $display("FAIL mid_sw_release got st=%0d ret=%0d want st=0 ret=0", state_o, retired); end
  endtask

  task automatic test_random();
    logic [5:0] tbl [11];
    int         k;
    logic [5:0] rop;
    tbl = '{OP_RTYPE, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGT, OP_BLT, OP_J,
            OP_ILL};
    for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_OP_TRAP_EN
      k = $urandom_range(0, 9);
`else
      k = $urandom_range(0, 10);
`endif
      rop = tbl[k];
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3), 0, -1);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(OP_LW, 0, 0, 0, -1);
    run_instr(OP_LW, 0, 0, 0, -1);
    run_instr(OP_SW, 0, 0, 0, -1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || retired !== model_cnt)
      begin n_err++; $display("FAIL final got st=%0d ret=%0d want st=0 ret=%0d", state_o, retired, model_cnt); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branches();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
